// File: rtl/hazard_pkg.sv
// Shared defaults and hazard-cause encoding for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;
  localparam int HZ_NUM_REGS   = 32;

  typedef enum logic [2:0] {
    NONE,
    LOAD_USE,
    RAW,
    WAW,
    FULL
  } hz_cause_e;

endpackage

// File: rtl/hazard_sb_bits.sv
// Per-register busy vector with set-over-clear priority and a registered popcount.
module hazard_sb_bits #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MAX_PENDING = 4,
  parameter int PC_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_idx_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic [PC_W-1:0]       cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [PC_W-1:0]     cnt_q, cnt_d;

  // Clear first, then set, so an issue and a writeback to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i && clr_idx_i != '0) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i && set_idx_i != '0) busy_d[set_idx_i] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_d = cnt_d + PC_W'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use stall plus busy scoreboard for long-latency producers.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = HZ_REG_ADDR_W,
  parameter int NUM_REGS    = HZ_NUM_REGS,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [REG_ADDR_W-1:0]              id_rs1,
  input  logic [REG_ADDR_W-1:0]              id_rs2,
  input  logic                               id_use_rs1,
  input  logic                               id_use_rs2,
  input  logic [REG_ADDR_W-1:0]              id_rd,
  input  logic                               id_reg_write,
  input  logic                               id_long,
  input  logic                               ex_mem_read,
  input  logic [REG_ADDR_W-1:0]              ex_rd,
  input  logic                               wb_valid,
  input  logic [REG_ADDR_W-1:0]              wb_rd,
  input  logic                               flush,
  output logic                               pc_write,
  output logic                               if_id_write,
  output logic                               control_sel,
  output logic [NUM_REGS-1:0]                busy_vec,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]                   stall_cycles
`endif
);

  localparam int PC_W = $clog2(MAX_PENDING + 1);

  if (NUM_REGS != 2**REG_ADDR_W || MAX_PENDING < 1 || MAX_PENDING > NUM_REGS || CNT_W < 1)
  begin : g_bad_cfg
    $error("hazard_scoreboard: inconsistent parameters");
  end

  logic      rs1_used, rs2_used;
  logic      lu, raw, waw, full, wb_clears;
  logic      stall, issue;
  hz_cause_e cause;

  assign rs1_used  = id_use_rs1 && id_rs1 != '0;
  assign rs2_used  = id_use_rs2 && id_rs2 != '0;
  assign wb_clears = wb_valid && wb_rd != '0 && busy_vec[wb_rd];

  assign lu  = ex_mem_read && ex_rd != '0 &&
               ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
  // A writeback to the same register this cycle reaches ID via register-file write-through.
  assign raw = (rs1_used && busy_vec[id_rs1] && !(wb_valid && wb_rd == id_rs1)) ||
               (rs2_used && busy_vec[id_rs2] && !(wb_valid && wb_rd == id_rs2));
  assign waw = id_reg_write && id_rd != '0 && busy_vec[id_rd] &&
               !(wb_valid && wb_rd == id_rd);
  assign full = id_long && id_reg_write && pending_cnt == PC_W'(MAX_PENDING) && !wb_clears;

  always_comb begin
    cause = NONE;
    if (lu)        cause = LOAD_USE;
    else if (raw)  cause = RAW;
    else if (waw)  cause = WAW;
    else if (full) cause = FULL;
  end

  assign stall = id_valid && !flush && cause != NONE;
  assign issue = id_valid && !stall && !flush && id_long && id_reg_write && id_rd != '0;

  // Reset holds the front end and feeds bubbles into ID/EX.
  assign pc_write    = !reset && !stall;
  assign if_id_write = !reset && !stall;
  assign control_sel = reset || stall;

  hazard_sb_bits #(
    .NUM_REGS    (NUM_REGS),
    .REG_ADDR_W  (REG_ADDR_W),
    .MAX_PENDING (MAX_PENDING),
    .PC_W        (PC_W)
  ) u_sb_bits (
    .clk       (clk),
    .rst       (reset),
    .set_en_i  (issue),
    .set_idx_i (id_rd),
    .clr_en_i  (wb_valid),
    .clr_idx_i (wb_rd),
    .busy_o    (busy_vec),
    .cnt_o     (pending_cnt)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expectation queue per step.
module tb_hazard_scoreboard;

  localparam int RW    = 5;
  localparam int NR    = 32;
  localparam int MP    = 4;
  localparam int CNT_W = 32;
  localparam int PCW   = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_long;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
  logic          ex_mem_read, wb_valid, flush;
  logic          pc_write, if_id_write, control_sel;
  logic [NR-1:0] busy_vec;
  logic [PCW-1:0] pending_cnt;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] exp_sc = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string         tag;
    logic          pcw;
    logic          csel;
    logic [NR-1:0] busy;
    int            cnt;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W  (RW),
    .NUM_REGS    (NR),
    .MAX_PENDING (MP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_long      (id_long),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .control_sel  (control_sel),
    .busy_vec     (busy_vec),
    .pending_cnt  (pending_cnt)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_long = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_mem_read = 0; ex_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic long_wr(input logic [RW-1:0] rd);
    id_valid = 1; id_long = 1; id_reg_write = 1; id_rd = rd;
  endtask

  // Inputs are already driven (at a negedge); check stall outputs, clock once, check state.
  task automatic step(input string tag, input logic pcw, input logic csel,
                      input logic [NR-1:0] busy, input int cnt);
    exp_t e;
    e.tag = tag; e.pcw = pcw; e.csel = csel; e.busy = busy; e.cnt = cnt;
    sbq.push_back(e);
    #1;
    chk({tag, ".pc_write"},    64'(pc_write),    64'(sbq[0].pcw));
    chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(sbq[0].pcw));
    chk({tag, ".control_sel"}, 64'(control_sel), 64'(sbq[0].csel));
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".busy_vec"},    64'(busy_vec),    64'(e.busy));
    chk({tag, ".pending_cnt"}, 64'(pending_cnt), 64'(e.cnt));
`ifdef HAZARD_STALL_CNT_EN
    if (reset) exp_sc = '0;
    else if (!e.pcw && exp_sc != '1) exp_sc = exp_sc + 1'b1;
    chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(exp_sc));
`endif
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step("reset_hold", 0, 1, '0, 0);
    reset = 0;

    // Load-use: one bubble, then the load has moved on.
    idle(); id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("lu_stall", 0, 1, '0, 0);
    ex_mem_read = 0;
    step("lu_release", 1, 0, '0, 0);
    idle(); id_valid = 1; ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step("lu_x0", 1, 0, '0, 0);
    idle(); id_valid = 1; ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
    step("lu_rs2", 0, 1, '0, 0);
    id_use_rs2 = 0;
    step("lu_rs2_unused", 1, 0, '0, 0);

    // Long RAW on x7.
    idle(); long_wr(7);
    step("issue_x7", 1, 0, 32'h80, 1);
    idle(); id_valid = 1; id_rs1 = 7; id_use_rs1 = 1;
    step("raw_x7_a", 0, 1, 32'h80, 1);
    step("raw_x7_b", 0, 1, 32'h80, 1);
    wb_valid = 1; wb_rd = 7;
    step("raw_x7_wb", 1, 0, '0, 0);

    // WAW on x3 with same-cycle set/clear.
    idle(); long_wr(3);
    step("issue_x3", 1, 0, 32'h8, 1);
    step("waw_x3", 0, 1, 32'h8, 1);
    wb_valid = 1; wb_rd = 3;
    step("waw_x3_wb", 1, 0, 32'h8, 1);

    // Fill the scoreboard.
    idle(); long_wr(10); step("issue_x10", 1, 0, 32'h408, 2);
    idle(); long_wr(11); step("issue_x11", 1, 0, 32'hC08, 3);
    idle(); long_wr(12); step("issue_x12", 1, 0, 32'h1C08, 4);
    idle(); long_wr(13);
    step("full_stall", 0, 1, 32'h1C08, 4);
    wb_valid = 1; wb_rd = 20;
    step("full_stray_wb", 0, 1, 32'h1C08, 4);
    wb_rd = 3;
    step("full_issue_on_wb", 1, 0, 32'h3C00, 4);

    // Flush kills stall and issue; scoreboard untouched.
    idle(); long_wr(14); id_rs1 = 10; id_use_rs1 = 1; flush = 1;
    step("flush", 1, 0, 32'h3C00, 4);
    idle(); id_rs1 = 10; id_use_rs1 = 1;
    step("no_valid", 1, 0, 32'h3C00, 4);
    idle(); wb_valid = 1; wb_rd = 5;
    step("wb_not_busy", 1, 0, 32'h3C00, 4);
    wb_rd = 0;
    step("wb_x0", 1, 0, 32'h3C00, 4);
    wb_rd = 10;
    step("wb_x10", 1, 0, 32'h3800, 3);

    // Asynchronous reset with three pending entries.
    idle(); reset = 1;
    #1;
    chk("async_rst.busy_vec",    64'(busy_vec),    64'd0);
    chk("async_rst.pending_cnt", 64'(pending_cnt), 64'd0);
    chk("async_rst.pc_write",    64'(pc_write),    64'd0);
    chk("async_rst.control_sel", 64'(control_sel), 64'd1);
    step("rst_held", 0, 1, '0, 0);
    reset = 0;
    wb_valid = 1; wb_rd = 11;
    step("post_rst_wb", 1, 0, '0, 0);

    // x0 destination never becomes busy; RAW via rs2.
    idle(); long_wr(0);
    step("issue_x0", 1, 0, '0, 0);
    idle(); long_wr(4);
    step("issue_x4", 1, 0, 32'h10, 1);
    idle(); id_valid = 1; id_rs2 = 4; id_use_rs2 = 1;
    step("raw_rs2", 0, 1, 32'h10, 1);
`ifdef HAZARD_STALL_CNT_EN
    for (int i = 0; i < 10; i++) step("cnt_run", 0, 1, 32'h10, 1);
`endif
    wb_valid = 1; wb_rd = 4;
    step("raw_rs2_wb", 1, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the ID stage of the RISC-V pipeline. It handles the classic single-cycle load-use stall. It also adds a per-register busy scoreboard for long-latency producers (variable-latency loads, multi-cycle mul/div) that complete out of band through a writeback handshake. It drives the PC write enable, the IF/ID write enable and the control-bubble select, and sits alongside the ID/EX pipeline register.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- NUM_REGS, 32, architectural registers (must equal 2**REG_ADDR_W)
- MAX_PENDING, 4, max simultaneously busy registers (1..NUM_REGS)
- CNT_W, 32, stall counter width (used only with the macro)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  async active-high reset
- ID-stage inputs:
  - id_valid  in  1  valid instruction in ID
  - id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
  - id_use_rs1, id_use_rs2  in  1  source actually read
  - id_rd  in  REG_ADDR_W  ID destination
  - id_reg_write  in  1  ID instruction writes id_rd
  - id_long  in  1  ID instruction is long-latency (scoreboarded)
- EX-stage inputs:
  - ex_mem_read  in  1  ID/EX holds a single-cycle load
  - ex_rd  in  REG_ADDR_W  ID/EX destination
- Writeback and flush inputs:
  - wb_valid  in  1  long-latency result written this cycle
  - wb_rd  in  REG_ADDR_W  its destination
  - flush  in  1  branch/jump kill of IF/ID
- Outputs:
  - pc_write  out  1  PC update enable
  - if_id_write  out  1  IF/ID update enable
  - control_sel  out  1  1 = inject bubble into ID/EX
  - busy_vec  out  NUM_REGS  scoreboard bits
  - pending_cnt  out  $clog2(MAX_PENDING+1)  busy bit count
  - stall_cycles  out  CNT_W  (macro only) stall counter

## Operation
- Register x0 is never a hazard. Reads and writes of index 0 are ignored everywhere.
- Load-use hazard (lu): ex_mem_read && ex_rd!=0 && matches any used source (id_use_rsN && id_rsN==ex_rd).
- RAW hazard (raw): a used source has busy_vec bit set, unless wb_valid && wb_rd equals that source this cycle. In that case the register file write-through supplies the value and there is no stall.
- WAW hazard (waw): id_reg_write && id_rd!=0 && busy_vec[id_rd] && !(wb_valid && wb_rd==id_rd).
- Full hazard (full): id_long && id_reg_write && pending_cnt==MAX_PENDING, and no wb_valid clearing a bit this cycle.
- Stall: stall = id_valid && !flush && (lu | raw | waw | full).
- Stall outputs: pc_write=!stall, if_id_write=!stall, control_sel=stall.
- flush: suppresses stall and issue. The scoreboard is not cleared, because in-flight long ops still write back.
- Issue: id_valid && !stall && !flush && id_long && id_reg_write && id_rd!=0 sets busy_vec[id_rd] at the next edge.
- Clear: wb_valid && wb_rd!=0 clears busy_vec[wb_rd]. A wb_valid for a register that is not busy is ignored.
- Same-register set and clear in one cycle: set wins (bit stays 1).
- pending_cnt is the registered popcount of busy_vec. It never exceeds MAX_PENDING.

## Timing
- Stall outputs are combinational from the inputs and registered busy_vec, with 0-cycle latency.
- Scoreboard updates on the rising clk edge.
- A load-use stall lasts exactly 1 cycle. A RAW or WAW stall releases in the same cycle as the matching wb_valid.
- While reset is asserted:
  - busy_vec=0, pending_cnt=0, stall_cycles=0.
  - pc_write=0, if_id_write=0, control_sel=1 (pipeline held with a bubble).
- Reset mid-operation drops all pending entries. Any later stray wb_valid is ignored.

## Configuration
- HAZARD_STALL_CNT_EN: when defined, stall_cycles increments every cycle stall=1 and saturates at all-ones.
- Without the macro, the stall_cycles port and its logic are absent.

## Structure
- Shared package hazard_pkg holds:
  - the REG_ADDR_W and NUM_REGS defaults
  - the hazard-cause enum (NONE, LOAD_USE, RAW, WAW, FULL) for debug/trace
- Sub-module hazard_sb_bits: busy vector, set/clear priority, popcount.
- The top level holds the compare/stall logic and the optional counter.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 used -> stall for exactly 1 cycle (pc_write=0, control_sel=1). Same case with ex_rd=0 -> no stall.
- Long RAW: issue div to x7. Next instruction reads x7 -> stall until wb_valid with wb_rd=7; released in that same cycle; busy_vec[7] clears at the next edge.
- WAW and same-cycle set/clear: x3 busy, ID long write to x3 -> stall. With wb_valid wb_rd=3 on the same cycle -> issue proceeds and busy_vec[3] stays 1.
- Full: MAX_PENDING=4, four distinct long issues -> pending_cnt=4. A fifth long issue stalls; it issues in the cycle a wb_valid arrives.
- Flush and reset: a stall condition with flush=1 -> no stall and no issue. Assert reset with 3 pending -> busy_vec=0 immediately; a later wb_valid changes nothing.
- With HAZARD_STALL_CNT_EN: 10 stalled cycles -> stall_cycles=10. With CNT_W=2 -> saturates at 3.
